// File: rtl/cpu_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute bundle of the decode stage.
// The stage takes the slave view; the environment takes the master view.
interface cpu_decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [REG_AW-1:0] src_reg1;
  logic [REG_AW-1:0] src_reg2;
  logic [REG_AW-1:0] dst_reg;
  logic              uses_src1;
  logic              uses_src2;
  logic              immediate;
  logic [DATA_W-1:0] immediate_value;
  logic              jump;
  logic              branch;
  logic [DATA_W-1:0] jump_address;
  logic [3:0]        aluop;
  logic              write_reg;
  logic              write_mem;
  logic              read_mem;
  logic              illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, src_reg1, src_reg2, dst_reg,
           uses_src1, uses_src2, immediate, immediate_value, jump, branch,
           jump_address, aluop, write_reg, write_mem, read_mem, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, src_reg1, src_reg2, dst_reg,
           uses_src1, uses_src2, immediate, immediate_value, jump, branch,
           jump_address, aluop, write_reg, write_mem, read_mem, illegal
  );
endinterface

// File: rtl/cpu_decode_stage.sv
// Registered MIPS-subset decode stage with valid/ready handshake on both sides
// and a load scoreboard that stalls readers of registers with a pending load.
module cpu_decode_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int PC_W         = 32,
  parameter int SIGN_EXT_IMM = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  cpu_decode_stage_if.slave io
);
  localparam int NREG = 1 << REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_NEQ = 4'd8;
  localparam logic [3:0] ALUOP_EQ  = 4'd9;

  typedef struct packed {
    logic [REG_AW-1:0] src_reg1;
    logic [REG_AW-1:0] src_reg2;
    logic [REG_AW-1:0] dst_reg;
    logic              uses_src1;
    logic              uses_src2;
    logic              immediate;
    logic [DATA_W-1:0] immediate_value;
    logic              jump;
    logic              branch;
    logic [DATA_W-1:0] jump_address;
    logic [3:0]        aluop;
    logic              write_reg;
    logic              write_mem;
    logic              read_mem;
    logic              illegal;
  } dec_t;

  dec_t              dec, dec_q, dec_d;
  logic [REG_AW-1:0] rs_x, rt_x, rd_x;
  logic [DATA_W-1:0] imm_x, jmp_x;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              haz1, haz2, in_ready, accept;

  assign rs_x  = REG_AW'(io.in_instr[25:21]);
  assign rt_x  = REG_AW'(io.in_instr[20:16]);
  assign rd_x  = REG_AW'(io.in_instr[15:11]);
  assign imm_x = (SIGN_EXT_IMM != 0) ? DATA_W'($signed(io.in_instr[15:0]))
                                     : DATA_W'(io.in_instr[15:0]);
  assign jmp_x = DATA_W'(io.in_instr[25:0]);

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec                 = '0;
    dec.aluop           = ALUOP_ADD;
    dec.immediate_value = imm_x;
    case (io.in_instr[31:26])
      OP_RTYPE: begin
        dec.src_reg1 = rs_x; dec.src_reg2 = rt_x; dec.dst_reg = rd_x;
        dec.uses_src1 = 1'b1; dec.uses_src2 = 1'b1; dec.write_reg = 1'b1;
      end
      OP_ADDI: begin
        dec.src_reg1 = rs_x; dec.dst_reg = rt_x; dec.uses_src1 = 1'b1;
        dec.immediate = 1'b1; dec.write_reg = 1'b1;
      end
      OP_LW: begin
        dec.src_reg1 = rs_x; dec.dst_reg = rt_x; dec.uses_src1 = 1'b1;
        dec.immediate = 1'b1; dec.read_mem = 1'b1; dec.write_reg = 1'b1;
      end
      OP_SW: begin
        dec.src_reg1 = rs_x; dec.src_reg2 = rt_x;
        dec.uses_src1 = 1'b1; dec.uses_src2 = 1'b1;
        dec.immediate = 1'b1; dec.write_mem = 1'b1;
      end
      OP_BNE, OP_BEQ: begin
        dec.src_reg1 = rs_x; dec.src_reg2 = rt_x;
        dec.uses_src1 = 1'b1; dec.uses_src2 = 1'b1;
        dec.branch = 1'b1; dec.jump_address = imm_x;
        dec.aluop = (io.in_instr[31:26] == OP_BEQ) ? ALUOP_EQ : ALUOP_NEQ;
      end
      OP_J: begin
        dec.jump = 1'b1; dec.jump_address = jmp_x;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (io.in_instr == 32'h0) begin
      dec.write_reg = 1'b0; dec.write_mem = 1'b0; dec.read_mem = 1'b0;
    end
    if (dec.dst_reg == '0) dec.write_reg = 1'b0;
  end

  // A writeback landing this cycle releases its reader without waiting a cycle.
  assign haz1 = dec.uses_src1 && (dec.src_reg1 != '0) && busy_q[dec.src_reg1]
                && !(wb_valid && (wb_reg == dec.src_reg1));
  assign haz2 = dec.uses_src2 && (dec.src_reg2 != '0) && busy_q[dec.src_reg2]
                && !(wb_valid && (wb_reg == dec.src_reg2));

  assign in_ready = !flush && !haz1 && !haz2 && (!out_valid_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    pc_d        = pc_q;
    busy_d      = busy_q;
    if (flush)            out_valid_d = 1'b0;
    else if (accept)      out_valid_d = 1'b1;
    else if (io.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      dec_d = dec;
      pc_d  = io.in_pc;
    end
    if (wb_valid && (wb_reg != '0)) busy_d[wb_reg] = 1'b0;
    // A flushed load never writes back, so its reservation must go with it.
    if (flush && out_valid_q && dec_q.read_mem) busy_d[dec_q.dst_reg] = 1'b0;
    if (accept && dec.read_mem && (dec.dst_reg != '0)) busy_d[dec.dst_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      pc_q        <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
    end
  end

  assign io.in_ready        = in_ready;
  assign io.out_valid       = out_valid_q;
  assign io.out_pc          = pc_q;
  assign io.src_reg1        = dec_q.src_reg1;
  assign io.src_reg2        = dec_q.src_reg2;
  assign io.dst_reg         = dec_q.dst_reg;
  assign io.uses_src1       = dec_q.uses_src1;
  assign io.uses_src2       = dec_q.uses_src2;
  assign io.immediate       = dec_q.immediate;
  assign io.immediate_value = dec_q.immediate_value;
  assign io.jump            = dec_q.jump;
  assign io.branch          = dec_q.branch;
  assign io.jump_address    = dec_q.jump_address;
  assign io.aluop           = dec_q.aluop;
  assign io.write_reg       = dec_q.write_reg;
  assign io.write_mem       = dec_q.write_mem;
  assign io.read_mem        = dec_q.read_mem;
  assign io.illegal         = dec_q.illegal;
endmodule
